// File: rtl/sregn_skid_pkg.sv
// rtl/sregn_skid_pkg.sv - shared elastic-buffer state encoding, transfer macro and control struct
// Purpose: common definitions for sregn_skid and later elastic blocks.
// Contents: PICO_XFER(v,r) transfer macro, SKID_* state codes, skid_ctrl_t
//           register-load controls, skid_count() state-to-occupancy helper.

`ifndef PICO_XFER
`define PICO_XFER(v, r) ((v) & (r))
`endif

package sregn_skid_pkg;

    localparam logic [1:0] SKID_EMPTY = 2'd0;
    localparam logic [1:0] SKID_ONE   = 2'd1;
    localparam logic [1:0] SKID_FULL  = 2'd2;

    // Load controls for the two data registers, produced by the FSM each cycle.
    typedef struct packed {
        logic main_en;
        logic main_from_skid;
        logic skid_en;
    } skid_ctrl_t;

    function automatic logic [1:0] skid_count(input logic [1:0] st);
        case (st)
            SKID_ONE:  skid_count = 2'd1;
            SKID_FULL: skid_count = 2'd2;
            default:   skid_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sregn_skid_if.sv
// rtl/sregn_skid_if.sv - upstream/downstream handshake bundle for sregn_skid
// Purpose: groups both valid/ready streams and the occupancy output.
// Signals: in_valid/in_data/in_ready (upstream), out_valid/out_data/out_ready
//          (downstream), count (occupancy 0..2).
// Modports: master = environment side, slave = buffer side.

interface sregn_skid_if #(
    parameter int width = 32
);
    logic             in_valid;
    logic [width-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [width-1:0] out_data;
    logic             out_ready;
    logic [1:0]       count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/sregn_noinit.sv
// rtl/sregn_noinit.sv - enable-load data register with synchronous active-low clear
// Purpose: one data entry of the elastic buffer.
// Ports: clk, reset (sync, active-low, clears q), en (load d), d, q.

module sregn_noinit #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sregn_skid.sv
// rtl/sregn_skid.sv - two-entry elastic pipeline register with registered in_ready
// Purpose: decouples an upstream producer from a downstream consumer without
//          losing or duplicating words; in_ready comes straight from a flop.
// Ports: clk, reset (sync, active-low), enable (global stall),
//        bus (sregn_skid_if.slave: in_valid/in_data/in_ready,
//        out_valid/out_data/out_ready, count).

module sregn_skid
    import sregn_skid_pkg::*;
#(
    parameter int width = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    sregn_skid_if.slave   bus
);

    logic [1:0]       state_q;
    logic [1:0]       next_state;
    logic [1:0]       count_q;
    logic             in_ready_q;
    skid_ctrl_t       ctrl;
    logic             in_ready_eff;
    logic             out_valid_eff;
    logic             accept;
    logic             drain;
    logic [width-1:0] main_q;
    logic [width-1:0] skid_q;
    logic [width-1:0] main_d;

    // Stall masks both handshakes so no transfer can happen while frozen.
    assign in_ready_eff  = in_ready_q & enable;
    assign out_valid_eff = (state_q != SKID_EMPTY) & enable;

    assign accept = `PICO_XFER(bus.in_valid, in_ready_eff);
    assign drain  = `PICO_XFER(out_valid_eff, bus.out_ready);

    always_comb begin
        next_state = state_q;
        ctrl       = '0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    next_state   = SKID_ONE;
                    ctrl.main_en = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && drain) begin
                    ctrl.main_en = 1'b1;
                end else if (accept) begin
                    next_state   = SKID_FULL;
                    ctrl.skid_en = 1'b1;
                end else if (drain) begin
                    next_state = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready_q is low here, so only a drain can occur.
                if (drain) begin
                    next_state          = SKID_ONE;
                    ctrl.main_en        = 1'b1;
                    ctrl.main_from_skid = 1'b1;
                end
            end
            default: begin
                next_state = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= SKID_EMPTY;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else if (enable) begin
            state_q    <= next_state;
            count_q    <= skid_count(next_state);
            in_ready_q <= (next_state != SKID_FULL);
        end
    end

    // Head register refills from the skid entry when a full buffer drains.
    assign main_d = ctrl.main_from_skid ? skid_q : bus.in_data;

    sregn_noinit #(.width(width)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl.main_en),
        .d     (main_d),
        .q     (main_q)
    );

    sregn_noinit #(.width(width)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl.skid_en),
        .d     (bus.in_data),
        .q     (skid_q)
    );

    assign bus.in_ready  = in_ready_eff;
    assign bus.out_valid = out_valid_eff;
    assign bus.out_data  = main_q;
    assign bus.count     = count_q;

endmodule
